// File: rtl/hub75_plane_fetch.sv
// hub75_plane_fetch: reads one row pair from the frame buffer and packs one bit-plane into six column vectors
//   clock, reset_n        : clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   : plane request handshake; req_row/req_plane latched on acceptance
//   mem_rd_en/mem_addr    : frame-buffer read strobe and address {half,row,col}
//   mem_rdata             : pixel {R,G,B}, returned one cycle after the read
//   plane_valid/plane_ack : output handshake for r1,g1,b1 (row r) and r2,g2,b2 (row r+ROWS/2)
//   busy                  : high whenever a request is being processed
module hub75_plane_fetch #(
    parameter int COLS       = 64,
    parameter int ROWS       = 64,
    parameter int COLOR_BITS = 4,
    parameter int AW         = $clog2(ROWS*COLS)
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [$clog2(ROWS/2)-1:0]       req_row,
    input  logic [$clog2(COLOR_BITS):0]     req_plane,
    output logic                            mem_rd_en,
    output logic [AW-1:0]                   mem_addr,
    input  logic [3*COLOR_BITS-1:0]         mem_rdata,
    output logic                            plane_valid,
    input  logic                            plane_ack,
    output logic [COLS-1:0]                 r1,
    output logic [COLS-1:0]                 g1,
    output logic [COLS-1:0]                 b1,
    output logic [COLS-1:0]                 r2,
    output logic [COLS-1:0]                 g2,
    output logic [COLS-1:0]                 b2,
    output logic                            busy
);
    localparam int CB  = COLOR_BITS;
    localparam int RW  = $clog2(ROWS/2);
    localparam int CW  = $clog2(2*COLS);
    localparam int PIW = $clog2(CB);
    localparam int PW  = PIW + 1;
    localparam logic [CW-1:0] LAST = CW'(2*COLS-1);
    localparam logic [PW-1:0] CBL  = PW'(CB);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, LOAD, ZERO} state_t;
    state_t state, nxt;

    logic [CW-1:0] cnt;
    logic [RW-1:0] row_q;
    logic [PIW-1:0] pi_q;
    logic rd_q, half_q;
    logic [CW-2:0] col_q;
    logic [5:0][COLS-1:0] abuf, vec;
    logic [CB-1:0] rr, gg, bb;
    logic [2:0] base;
    logic accept, oor, load, zero;

    assign rr = mem_rdata[3*CB-1:2*CB];
    assign gg = mem_rdata[2*CB-1:CB];
    assign bb = mem_rdata[CB-1:0];
    assign oor = req_plane >= CBL;
    assign base = half_q ? 3'd3 : 3'd0;
    // cnt[0] alternates top/bottom; the address holds once cnt stops counting
    assign mem_addr = {cnt[0], row_q, cnt[CW-1:1]};
    assign {b2, g2, r2, b1, g1, r1} = vec;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? (oor ? ZERO : FETCH) : IDLE;
            FETCH:   nxt = (cnt == LAST) ? DRAIN : FETCH;
            DRAIN:   nxt = LOAD;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en = state == FETCH;
        busy      = state != IDLE;
        load      = state == LOAD;
        zero      = state == ZERO;
        req_ready = (state == IDLE) && (!plane_valid || plane_ack);
        accept    = req_valid && req_ready;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            row_q       <= '0;
            pi_q        <= '0;
            rd_q        <= 1'b0;
            half_q      <= 1'b0;
            col_q       <= '0;
            abuf        <= '0;
            vec         <= '0;
            plane_valid <= 1'b0;
        end else begin
            // rd_q/half_q/col_q tag the return that arrives on the next cycle
            rd_q   <= mem_rd_en;
            half_q <= cnt[0];
            col_q  <= cnt[CW-1:1];
            if (accept && !oor) begin
                cnt   <= '0;
                row_q <= req_row;
                pi_q  <= req_plane[PIW-1:0];
            end else if (mem_rd_en && cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end
            if (rd_q) begin
                abuf[base][col_q]        <= rr[pi_q];
                abuf[base + 3'd1][col_q] <= gg[pi_q];
                abuf[base + 3'd2][col_q] <= bb[pi_q];
            end
            if (load) vec <= abuf;
            else if (zero) vec <= '0;
            plane_valid <= (load || zero) ? 1'b1 : plane_ack ? 1'b0 : plane_valid;
        end
    end
endmodule

// File: tb/tb_hub75_plane_fetch.sv
// tb_hub75_plane_fetch: randomized and directed checks of hub75_plane_fetch against a cycle-count model
module tb_hub75_plane_fetch;
    logic clock = 0, reset_n = 0, req_valid = 0, plane_ack = 0;
    logic req_ready, mem_rd_en, plane_valid, busy;
    logic [4:0] req_row = 0;
    logic [2:0] req_plane = 0;
    logic [11:0] mem_addr, mem_rdata;
    logic [63:0] r1, g1, b1, r2, g2, b2;
    logic [11:0] mem [4096];
    int checks = 0, errors = 0, mode = 0;

    int m_left = 0;
    logic m_pv = 0, m_rd = 0, m_norm = 0;
    logic [4:0] m_row = 0;
    logic [11:0] m_addr = 0;
    logic [5:0][63:0] m_vec = '0, m_nxt = '0;

    hub75_plane_fetch dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_row(req_row), .req_plane(req_plane), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .plane_valid(plane_valid), .plane_ack(plane_ack),
        .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2), .busy(busy)
    );

    always #5 clock = ~clock;

    // synchronous RAM; garbage on cycles with no read so stray captures show up
    always @(posedge clock) mem_rdata <= mem_rd_en ? mem[mem_addr] : 12'($urandom);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [5:0][63:0] exp_plane(input int row, input int pl);
        logic [5:0][63:0] v;
        logic [11:0] t, b;
        v = '0;
        if (pl < 4)
            for (int c = 0; c < 64; c++) begin
                t = mem[row*64 + c];
                b = mem[2048 + row*64 + c];
                v[0][c] = t[8+pl]; v[1][c] = t[4+pl]; v[2][c] = t[pl];
                v[3][c] = b[8+pl]; v[4][c] = b[4+pl]; v[5][c] = b[pl];
            end
        return v;
    endfunction

    // model: an accepted request occupies 130 cycles (normal) or 1 (zero plane)
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_left = 0; m_pv = 0; m_rd = 0; m_norm = 0; m_addr = 0; m_vec = '0; m_row = 0;
        end else begin
            automatic bit acc = req_valid && m_left == 0 && (!m_pv || plane_ack);
            automatic bit set = m_left == 1;
            automatic int k;
            if (m_left > 0) m_left--;
            if (set) begin m_pv = 1; m_vec = m_nxt; end
            else if (plane_ack) m_pv = 0;
            if (acc) begin
                m_norm = req_plane < 4;
                m_left = m_norm ? 130 : 1;
                m_row  = req_row;
                m_nxt  = exp_plane(req_row, req_plane);
            end
            k = 130 - m_left;
            m_rd = m_norm && m_left > 0 && k < 128;
            if (m_rd) m_addr = 12'((k % 2) * 2048 + m_row * 64 + k / 2);
        end
    end

    always @(negedge clock) begin
        chk("req_ready", req_ready, m_left == 0 && (!m_pv || plane_ack));
        chk("busy", busy, m_left > 0);
        chk("mem_rd_en", mem_rd_en, m_rd);
        chk("mem_addr", mem_addr, m_addr);
        chk("plane_valid", plane_valid, m_pv);
        chk("r1", r1, m_vec[0]); chk("g1", g1, m_vec[1]); chk("b1", b1, m_vec[2]);
        chk("r2", r2, m_vec[3]); chk("g2", g2, m_vec[4]); chk("b2", b2, m_vec[5]);
    end

    task automatic step();
        @(posedge clock);
        #1;
        plane_ack = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
    endtask

    task automatic accept(input int row, input int pl);
        int n = 0;
        req_valid = 1; req_row = 5'(row); req_plane = 3'(pl);
        #1;
        while (!req_ready && n < 200) begin step(); #1; n++; end
        chk("accept_timeout", req_ready, 1);
        step();
        req_valid = 0; req_row = 5'($urandom); req_plane = 3'($urandom);
    endtask

    task automatic wait_pv(output int lat, output int nrd, output int runs,
                           output logic [11:0] first, output logic [11:0] last);
        logic prev = 0;
        lat = 0; nrd = 0; runs = 0; first = 0; last = 0;
        while (!plane_valid && lat < 300) begin
            if (mem_rd_en) begin
                if (nrd == 0) first = mem_addr;
                last = mem_addr; nrd++;
                if (!prev) runs++;
            end
            prev = mem_rd_en;
            step(); lat++;
        end
        chk("pv_timeout", plane_valid, 1);
    endtask

    int lat, nrd, runs;
    logic [11:0] fa, la;
    localparam logic [63:0] ONES = '1;

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = {a[3:0], a[9:6], 4'hF};
        step(); step();
        chk("rst_pv", plane_valid, 0); chk("rst_rd", mem_rd_en, 0); chk("rst_busy", busy, 0);
        chk("rst_addr", mem_addr, 0); chk("rst_r1", r1, 0); chk("rst_ready", req_ready, 1);
        reset_n = 1;
        step();

        accept(5, 0); wait_pv(lat, nrd, runs, fa, la);
        chk("lat_grad", lat, 130);
        chk("grad_r1", r1, 64'hAAAA_AAAA_AAAA_AAAA); chk("grad_r2", r2, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("grad_g1", g1, ONES); chk("grad_g2", g2, ONES);
        chk("grad_b1", b1, ONES); chk("grad_b2", b2, ONES);

        req_valid = 1; req_row = 31; req_plane = 3;
        for (int i = 0; i < 8; i++) begin step(); chk("bp_ready", req_ready, 0); end
        chk("bp_hold_r1", r1, 64'hAAAA_AAAA_AAAA_AAAA);
        mode = 1; plane_ack = 1; #1;
        chk("bp_ready_ack", req_ready, 1);
        step();
        req_valid = 0;
        chk("bp_pv_clr", plane_valid, 0); chk("bp_busy", busy, 1);
        wait_pv(lat, nrd, runs, fa, la);
        chk("trace_lat", lat, 130); chk("trace_n", nrd, 128); chk("trace_runs", runs, 1);
        chk("trace_first", fa, 12'h7C0); chk("trace_last", la, 12'hFFF);
        chk("p3_r1", r1, 64'hFF00_FF00_FF00_FF00); chk("p3_r2", r2, 64'hFF00_FF00_FF00_FF00);

        accept(3, 4); wait_pv(lat, nrd, runs, fa, la);
        chk("zero_lat", lat, 1); chk("zero_rd", nrd, 0);
        chk("zero_vec", r1 | g1 | b1 | r2 | g2 | b2, 0);

        accept(0, 1); wait_pv(lat, nrd, runs, fa, la);
        chk("row0_r1", r1, 64'hCCCC_CCCC_CCCC_CCCC); chk("row0_g1", g1, 0); chk("row32_g2", g2, 0);
        accept(31, 2); wait_pv(lat, nrd, runs, fa, la);
        chk("row31_lat", lat, 130); chk("row31_r1", r1, 64'hF0F0_F0F0_F0F0_F0F0);
        chk("row31_g1", g1, ONES); chk("row63_g2", g2, ONES);

        accept(7, 1);
        for (int i = 0; i < 40; i++) step();
        reset_n = 0; #1;
        chk("mid_pv", plane_valid, 0); chk("mid_rd", mem_rd_en, 0); chk("mid_busy", busy, 0);
        chk("mid_r1", r1, 0); chk("mid_b2", b2, 0); chk("mid_addr", mem_addr, 0);
        step(); step();
        reset_n = 1;
        step();
        accept(12, 2); wait_pv(lat, nrd, runs, fa, la);
        chk("post_rst_lat", lat, 130);

        for (int a = 0; a < 4096; a++) mem[a] = 12'($urandom);
        mode = 2;
        for (int i = 0; i < 25; i++) begin
            automatic int pl = $urandom_range(0, 7);
            accept($urandom_range(0, 31), pl);
            wait_pv(lat, nrd, runs, fa, la);
            chk("rand_lat", lat, pl < 4 ? 130 : 1);
            chk("rand_nrd", nrd, pl < 4 ? 128 : 0);
            repeat ($urandom_range(0, 3)) step();
        end
        mode = 1;
        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
